// File: rtl/agu_arbiter.sv
// agu_arbiter: two-requester address generation unit with a one-entry result register.
// Define AGUARB_RR_EN for round-robin arbitration; default build is fixed priority with starvation guard.
module agu_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [2:0]  req0_mode,
   input  logic [2:0]  req1_mode,
   input  logic [31:0] req0_base,
   input  logic [31:0] req0_idx,
   input  logic [31:0] req0_disp,
   input  logic [31:0] req1_base,
   input  logic [31:0] req1_idx,
   input  logic [31:0] req1_disp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_addr,
   output logic        out_src,
   output logic        out_fault
);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t      r_state;
   logic        w_space;
   logic        w_accept;
   logic        w_grant;
   logic [2:0]  w_mode;
   logic [31:0] w_base;
   logic [31:0] w_t;
   logic [31:0] w_addr;
   logic        w_fault;

   assign w_space    = (r_state == IDLE) || out_ready;
   assign w_accept   = w_space && (req0_valid || req1_valid);
   assign req0_ready = reset_n && w_accept && !w_grant;
   assign req1_ready = reset_n && w_accept && w_grant;
   assign out_valid  = (r_state == HOLD);

`ifdef AGUARB_RR_EN
   logic r_rr;
   assign w_grant = (req0_valid && req1_valid) ? r_rr : req1_valid;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_rr <= 1'b0;
      else if (w_accept) r_rr <= !w_grant;
`else
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] r_starve;
   assign w_grant = req1_valid && (!req0_valid || r_starve >= CW'(STARVE_MAX));
   // Counts port-0 wins only while port 1 is waiting; any break in req1_valid restarts the streak.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_starve <= '0;
      else if (!req1_valid || (w_accept && w_grant)) r_starve <= '0;
      else if (w_accept && r_starve < CW'(STARVE_MAX)) r_starve <= r_starve + 1'b1;
`endif

   assign w_mode  = w_grant ? req1_mode : req0_mode;
   assign w_base  = w_grant ? req1_base : req0_base;
   assign w_t     = w_grant ? req1_idx + req1_disp : req0_idx + req0_disp;
   assign w_fault = (w_mode == 3'd0) || (w_mode == 3'd6);
   assign w_addr  = (w_mode >= 3'd1 && w_mode <= 3'd5) ? w_base + (w_t << (w_mode - 3'd1)) :
                    (w_mode == 3'd7) ? w_base : '0;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state   <= IDLE;
         out_addr  <= '0;
         out_src   <= 1'b0;
         out_fault <= 1'b0;
      end else if (w_accept) begin
         r_state   <= HOLD;
         out_addr  <= w_addr;
         out_src   <= w_grant;
         out_fault <= w_fault;
      end else if (out_ready) begin
         r_state   <= IDLE;
      end
endmodule

// File: doc/agu_arbiter.md
AGU_ARBITER -- requirements
Module: agu_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning: consecutive port-0 grants after which a waiting port 1 is forced through (fixed-priority build only).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester 0 (load/store) / requester 1 (fetch) request present.
REQ-005 req0_ready, req1_ready  output  1 each  request accepted this cycle when ready and valid are both high.
REQ-006 reqN_mode  input  3  per requester: 001 byte, 010 word, 011 dword, 100 qword, 101 oword, 111 mov, others invalid.
REQ-007 reqN_base, reqN_idx, reqN_disp  input  32 each  per-requester address operands.
REQ-008 out_valid  output  1  result register holds a result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_addr  output  32  generated address.
REQ-011 out_src  output  1  requester that produced out_addr (0 or 1).
REQ-012 out_fault  output  1  result came from an invalid mode.

Function
REQ-013 Address: t = idx + disp (mod 2^32); out = base + (t << s), s = 0,1,2,3,4 for modes 001..101; mov gives base; all arithmetic is truncated to 32 bits.
REQ-014 An invalid mode (000, 110) gives out_addr 0 and out_fault 1; the request is still accepted and handshaken.
REQ-015 The FSM has two states: IDLE (result register empty) and HOLD (result register full).
REQ-016 IDLE: if any reqN_valid, grant one requester, load the result register, go to HOLD next cycle; latency is 1 cycle from acceptance to out_valid.
REQ-017 HOLD with out_ready=1: retire the result; if a request is valid in the same cycle, accept it and stay in HOLD (one result per cycle, no bubble); otherwise go to IDLE.
REQ-018 HOLD with out_ready=0: at most one ready is high; out_addr, out_src, and out_fault stay stable; out_valid stays 1.
REQ-019 req0_ready and req1_ready are never high in the same cycle; ready = grant AND (IDLE or out_ready).
REQ-020 readys depend combinationally on reqN_valid, out_ready, and state; there is no path from reqN operand inputs to any ready.
REQ-021 A single valid requester is always granted when space exists, regardless of arbitration state.
REQ-022 Round-robin pointer: after granting port k, priority passes to port 1-k; the pointer changes only on an accepted transfer.

Reset
REQ-023 While reset_n=0: state IDLE, out_valid 0, out_addr 0, out_src 0, out_fault 0, both readys 0, RR pointer on port 0, starvation counter 0.
REQ-024 Reset asserted mid-transfer discards the held result with no output handshake; the first grant after release follows REQ-023 priority.

Configuration
REQ-025 Macro AGUARB_RR_EN defined: round-robin per REQ-022 when both ports are valid.
REQ-026 AGUARB_RR_EN undefined: fixed priority, port 0 wins. A saturating counter counts consecutive port-0 grants while req1_valid=1. When it reaches STARVE_MAX, the next grant goes to port 1. The counter clears on any port-1 grant or any cycle with req1_valid=0.

Verification
REQ-027 Port 0 only: mode 011, base 0x1000, idx 2, disp 1, out_ready=1 -> next cycle out_valid=1, out_addr 0x100C, out_src 0.
REQ-028 Wrap: mode 101, base 0xFFFFFFF0, idx 1, disp 0 -> out_addr 0x00000000, out_fault 0.
REQ-029 Invalid mode 110 on port 1 -> out_addr 0, out_fault 1, out_src 1, handshake completes.
REQ-030 Backpressure: out_ready=0 for 5 cycles with both ports valid -> out_* stable, no ready high after the first accept; out_ready=1 -> back-to-back results with no idle cycle.
REQ-031 RR build, both ports valid continuously, out_ready=1 -> out_src alternates 0,1,0,1. Fixed build, STARVE_MAX=4 -> out_src sequence 0,0,0,0,1,0,0,0,0,1.
REQ-032 Assert reset_n=0 while in HOLD -> out_valid drops asynchronously to 0; after release, the first grant is port 0.
